// File: rtl/demux_pkg.sv
// Shared constants, state encoding and helpers for the 1-to-8 demux router.
package demux_pkg;
  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  typedef enum logic {EMPTY, FULL} demux_state_t;

  function automatic logic [N_OUT-1:0] onehot8(input logic [SEL_W-1:0] sel);
    logic [N_OUT-1:0] r;
    r = 8'h01 << sel;
    return r;
  endfunction
endpackage

// File: rtl/seq_counter.sv
// 3-bit wrapping counter with enable and synchronous reset; drives the round-robin destination.
module seq_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [2:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= 3'd0;
    else if (en) count <= count + 3'd1;
  end
endmodule

// File: rtl/demux18_router.sv
// One-to-eight word router with a single holding register and per-channel valid/ready.
module demux18_router
  import demux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STALL_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             auto_seq,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [2:0]       seq_idx,
  output logic             stall_err,
  input  logic             err_clr
);
  // Handshake: a word moves on a port in any cycle where valid and ready are both
  // high at the rising edge; valid never depends on the ready of the same port.
  localparam int CW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] SMAX    = CW'(STALL_MAX);
  localparam logic [CW-1:0] SMAX_M1 = CW'(STALL_MAX - 1);

  demux_state_t     state, state_next;
  logic [SEL_W-1:0] dst;
  logic [SEL_W-1:0] sel;
  logic [CW-1:0]    stall_cnt;
  logic             accept, drain, stall_inc;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    drain      = (state == FULL) & out_ready[dst];
    in_ready   = ~rst & ((state == EMPTY) | drain);
    accept     = in_valid & in_ready;
    sel        = auto_seq ? seq_idx : in_sel;
    out_valid  = (state == FULL) ? onehot8(dst) : 8'h00;
    stall_inc  = (state == FULL) & ~drain & (stall_cnt != SMAX);
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (drain && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // out_data keeps its last value after a drain; only a new accept replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      dst      <= '0;
    end else if (accept) begin
      out_data <= in_data;
      dst      <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept || drain || state == EMPTY) stall_cnt <= '0;
    else if (stall_inc)                           stall_cnt <= stall_cnt + CW'(1);
  end

  // Set on the increment that lands on STALL_MAX; set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                                stall_err <= 1'b0;
    else if (stall_inc && stall_cnt == SMAX_M1) stall_err <= 1'b1;
    else if (err_clr)                       stall_err <= 1'b0;
  end

  seq_counter u_seq (
    .clk   (clk),
    .rst   (rst),
    .en    (accept & auto_seq),
    .count (seq_idx)
  );
endmodule

// File: tb/tb_demux18_router.sv
// Directed bench for demux18_router with a channel/data scoreboard on every drain.
module tb_demux18_router;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic [2:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic         auto_seq;
  logic [W-1:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [2:0]   seq_idx;
  logic         stall_err;
  logic         err_clr;

  int checks = 0;
  int errors = 0;
  logic [W+2:0] exp_q[$];
  logic [2:0]   tb_seq = 3'd0;

  demux18_router #(.WIDTH(W), .STALL_MAX(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .auto_seq(auto_seq),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .seq_idx(seq_idx), .stall_err(stall_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs change only just after posedge, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (rst) begin
      exp_q.delete();
      tb_seq = 3'd0;
    end else begin
      if ((out_valid & out_ready) != 8'h00) begin
        if (exp_q.size() == 0) begin
          check("drain_unexpected", {24'h0, out_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("drain_channel", {24'h0, out_valid}, {24'h0, 8'h01 << e[W+2:W]});
          check("drain_data", {24'h0, out_data}, {24'h0, e[W-1:0]});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({auto_seq ? tb_seq : in_sel, in_data});
        if (auto_seq) tb_seq = tb_seq + 3'd1;
      end
    end
  end

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
    auto_seq = 1'b0; out_ready = 8'h00; err_clr = 1'b0;
    step(); step();
    check("rst_out_valid", {24'h0, out_valid}, 32'h0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_seq_idx", {29'h0, seq_idx}, 32'h0);
    check("rst_stall_err", {31'h0, stall_err}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Single word to channel 5, then drain.
    in_sel = 3'd5; in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ch5_valid", {24'h0, out_valid}, 32'h20);
    check("ch5_data", {24'h0, out_data}, 32'hA5);
    check("ch5_in_ready", {31'h0, in_ready}, 32'h0);
    out_ready = 8'h20;
    step();
    out_ready = 8'h00;
    check("ch5_drained", {24'h0, out_valid}, 32'h0);

    // Other channels' ready must not release a word for channel 2.
    in_sel = 3'd2; in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 8'hFB;
    step(); step();
    check("ch2_held_valid", {24'h0, out_valid}, 32'h04);
    check("ch2_held_data", {24'h0, out_data}, 32'h3C);
    check("ch2_in_ready", {31'h0, in_ready}, 32'h0);
    check("ch2_no_stall", {31'h0, stall_err}, 32'h0);
    out_ready = 8'hFF;
    step();
    check("ch2_drained", {24'h0, out_valid}, 32'h0);

    // Round-robin, back-to-back.
    auto_seq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = W'(i); in_valid = 1'b1;
      check("rr_in_ready", {31'h0, in_ready}, 32'h1);
      step();
      check("rr_valid", {24'h0, out_valid}, {24'h0, 8'h01 << (i % 8)});
    end
    in_valid = 1'b0;
    step();
    check("rr_seq_end", {29'h0, seq_idx}, 32'h2);
    check("rr_empty", {24'h0, out_valid}, 32'h0);
    auto_seq = 1'b0;

    // Stall detection with STALL_MAX=4.
    out_ready = 8'h00; in_sel = 3'd3; in_data = 8'h77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("stall_ramp", {31'h0, stall_err}, (k == 4) ? 32'h1 : 32'h0);
    end
    out_ready = 8'h08;
    step();
    out_ready = 8'h00;
    check("stall_drained", {24'h0, out_valid}, 32'h0);
    check("stall_sticky", {31'h0, stall_err}, 32'h1);
    check("seq_hold_manual", {29'h0, seq_idx}, 32'h2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("stall_cleared", {31'h0, stall_err}, 32'h0);

    // Reset while holding a word.
    in_sel = 3'd1; in_data = 8'h11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ch1_valid", {24'h0, out_valid}, 32'h02);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", {24'h0, out_valid}, 32'h0);
    check("midrst_seq", {29'h0, seq_idx}, 32'h0);
    check("midrst_stall", {31'h0, stall_err}, 32'h0);
    out_ready = 8'hFF; in_sel = 3'd6; in_data = 8'h66; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("after_rst_valid", {24'h0, out_valid}, 32'h40);
    step();
    check("after_rst_drained", {24'h0, out_valid}, 32'h0);

    // Drain and accept in the same cycle.
    out_ready = 8'h00; in_sel = 3'd4; in_data = 8'h44; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("b2b_first", {24'h0, out_valid}, 32'h10);
    out_ready = 8'hFF; in_sel = 3'd6; in_data = 8'h6E; in_valid = 1'b1;
    #1;
    check("b2b_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    check("b2b_second", {24'h0, out_valid}, 32'h40);
    check("b2b_data", {24'h0, out_data}, 32'h6E);
    step();
    check("b2b_drained", {24'h0, out_valid}, 32'h0);
    out_ready = 8'h00;
    step();
    check("queue_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux18_router.md
Name: demux18_router

Overview:
- 1-to-8 demultiplexer: the distribution counterpart of the 8:1 mux.
- A single input word stream is routed to one of eight output channels.
- Each channel has its own valid/ready handshake.
- One-entry output holding register; each word is held until its destination channel accepts it.
- Selection comes either from an explicit 3-bit select or from an internal round-robin sequencer (auto mode).
- Used wherever one producer fans out to eight consumers in the lab datapaths.

Parameters:
- WIDTH, 8, data word width in bits.
- STALL_MAX, 255, consecutive cycles a held word may wait before stall_err sets; legal range 1..65535.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  3  destination channel; ignored when auto_seq=1.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- auto_seq  input  1  1 = destination from the internal sequencer; 0 = destination from in_sel.
- out_data  output  WIDTH  held word, broadcast to all channels.
- out_valid  output  8  one-hot; bit k set = held word is for channel k.
- out_ready  input  8  per-channel accept.
- seq_idx  output  3  sequencer's next destination.
- stall_err  output  1  sticky: a held word waited STALL_MAX cycles.
- err_clr  input  1  clears stall_err.

Behaviour:
- Reset (rst=1 at the clock edge):
  - out_valid=0, out_data=0, seq_idx=0, stall_err=0, stall counter=0, state=EMPTY.
  - in_ready is low while rst=1 and high in the first cycle after reset.
- States:
  - EMPTY: no held word. out_valid=0, in_ready=1.
  - FULL: word held for channel dst. out_valid = one-hot(dst).
- Definitions:
  - accept = in_valid & in_ready.
  - drain = FULL & out_ready[dst]; bits of out_ready for other channels are ignored.
- in_ready = EMPTY | drain. This is combinational from out_ready, which gives full throughput of one word per cycle when the consumer is ready.
- Transitions:
  - EMPTY, accept → FULL. out_data <= in_data, dst <= selected channel.
  - FULL, drain & accept → FULL with the new word loaded. This is back-to-back operation: no bubble.
  - FULL, drain & !accept → EMPTY. out_data keeps its last value.
  - FULL, !drain → FULL. out_data and dst stable; in_ready=0.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N, i.e. one cycle.
- Destination selection:
  - Sampled only on accept: auto_seq ? seq_idx : in_sel.
  - seq_idx increments by 1 on each accept while auto_seq=1; it wraps 7→0.
  - seq_idx holds when auto_seq=0.
  - Toggling auto_seq while FULL does not change dst of the held word.
- Stall counter:
  - Clears on any accept or drain, and in EMPTY.
  - Otherwise increments while FULL & !drain, saturating at STALL_MAX.
  - stall_err sets on the cycle the counter reaches STALL_MAX.
  - stall_err stays set until err_clr=1 (or rst).
  - If set and clear occur in the same cycle, set wins.
  - The held word is never dropped.
- Reset mid-operation: a held word is discarded; the sequencer returns to 0.
- Width rules:
  - No arithmetic on data.
  - Stall counter width is $clog2(STALL_MAX+1).
  - seq_idx uses 3-bit modulo arithmetic.

Decomposition:
- Package demux_pkg:
  - N_OUT=8, SEL_W=3.
  - typedef enum logic {EMPTY, FULL} demux_state_t.
  - Function onehot8(sel) returning logic [7:0].
- Sub-module seq_counter: 3-bit wrap counter with enable and sync reset, used for seq_idx.
- The stall logic stays inline.

Test Plan:
- Reset, then in_sel=5, in_data=8'hA5, in_valid=1 for one cycle, out_ready=8'h00 → next cycle out_valid=8'b0010_0000, out_data=A5, in_ready=0. Then out_ready[5]=1 → out_valid=0 the following cycle.
- Hold the word for channel 2 with out_ready=8'b1111_1011 (all bits except channel 2 set) → word stays held, in_ready=0.
- auto_seq=1, out_ready=8'hFF, 10 back-to-back words 0..9 → out_valid cycles channels 0,1,…,7,0,1 on consecutive cycles with no bubbles; seq_idx=2 at the end.
- STALL_MAX=4, hold a word for channel 3 with out_ready=0 → stall_err rises 4 cycles after the load and remains set after the drain. err_clr=1 → stall_err=0 the next cycle.
- FULL for channel 1, assert rst for one cycle → out_valid=0, seq_idx=0, stall_err=0; the next accepted word is routed normally.
- FULL with drain and a new accept in the same cycle (in_sel 4→6) → out_valid moves 8'b0001_0000 → 8'b0100_0000 in one cycle; no word lost or duplicated, checked by the scoreboard.
